// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer sequencer: random pre-start delay, cheat detection, timeout and display select.
// Optional best-time register enabled by defining REACTION_BEST_EN.
module reaction_timer_ctrl #(
    parameter int          TICK_FINAL      = 99999,
    parameter int          MIN_DELAY_MS    = 2000,
    parameter int          DELAY_RAND_BITS = 13,
    parameter int          TIMEOUT_MS      = 1000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic       cnt_enable,
    output logic       cnt_stop,
    output logic       cnt_clear,
    output logic [1:0] disp_sel,
    output logic       busy,
`ifdef REACTION_BEST_EN
    output logic [9:0] best_ms,
`endif
    output logic [9:0] last_ms
);
    localparam int TW = (TICK_FINAL > 0) ? $clog2(TICK_FINAL + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_TIMING = 3'd2,
        S_DONE   = 3'd3,
        S_EARLY  = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_lfsr;
    logic [TW-1:0]   r_tick_cnt;
    logic [13:0]     r_ms_cnt;
    logic [13:0]     r_delay;
    logic            r_cnt_enable, r_cnt_stop, r_cnt_clear, r_busy;
    logic [1:0]      r_disp_sel;
    logic [9:0]      r_last_ms;

    logic            w_ms_tick, w_lfsr_fb;
    logic            w_en, w_stp, w_clr, w_cnt_rst, w_latch, w_last_upd, w_best_upd, w_busy_nxt;
    logic [1:0]      w_disp_nxt;
    logic [9:0]      w_last_val;

    assign w_ms_tick = (r_tick_cnt == TW'(TICK_FINAL));
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_comb begin
        w_state_nxt = r_state;
        w_en        = 1'b0;
        w_stp       = 1'b0;
        w_clr       = 1'b0;
        w_cnt_rst   = 1'b0;
        w_latch     = 1'b0;
        w_last_upd  = 1'b0;
        w_best_upd  = 1'b0;
        w_last_val  = r_last_ms;
        case (r_state)
            S_IDLE: if (start) begin
                w_latch     = 1'b1;
                w_cnt_rst   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // an early press beats delay expiry in the same cycle
                if (stop) begin
                    w_stp       = 1'b1;
                    w_state_nxt = S_EARLY;
                end else if (w_ms_tick && (r_ms_cnt + 14'd1 == r_delay)) begin
                    w_en        = 1'b1;
                    w_cnt_rst   = 1'b1;
                    w_state_nxt = S_TIMING;
                end
            end
            S_TIMING: begin
                if (stop) begin
                    w_stp       = 1'b1;
                    w_last_upd  = 1'b1;
                    w_best_upd  = 1'b1;
                    w_last_val  = r_ms_cnt[9:0];
                    w_state_nxt = S_DONE;
                end else if (w_ms_tick && (r_ms_cnt == 14'(TIMEOUT_MS - 1))) begin
                    w_stp       = 1'b1;
                    w_last_upd  = 1'b1;
                    w_last_val  = 10'(TIMEOUT_MS);
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE, S_EARLY: if (clear) begin
                w_clr       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_WAIT:           w_disp_nxt = 2'd1;
            S_TIMING, S_DONE: w_disp_nxt = 2'd2;
            S_EARLY:          w_disp_nxt = 2'd3;
            default:          w_disp_nxt = 2'd0;
        endcase
        w_busy_nxt = (w_state_nxt == S_WAIT) || (w_state_nxt == S_TIMING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr       <= LFSR_SEED;
            r_tick_cnt   <= '0;
            r_ms_cnt     <= '0;
            r_delay      <= '0;
            r_cnt_enable <= 1'b0;
            r_cnt_stop   <= 1'b0;
            r_cnt_clear  <= 1'b0;
            r_disp_sel   <= 2'd0;
            r_busy       <= 1'b0;
            r_last_ms    <= '0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            if (w_cnt_rst) begin
                r_tick_cnt <= '0;
                r_ms_cnt   <= '0;
            end else begin
                r_tick_cnt <= w_ms_tick ? '0 : r_tick_cnt + TW'(1);
                if (w_ms_tick && (r_ms_cnt != 14'h3FFF)) r_ms_cnt <= r_ms_cnt + 14'd1;
            end
            if (w_latch) r_delay <= 14'(MIN_DELAY_MS) + 14'(r_lfsr[DELAY_RAND_BITS-1:0]);
            r_cnt_enable <= w_en;
            r_cnt_stop   <= w_stp;
            r_cnt_clear  <= w_clr;
            r_disp_sel   <= w_disp_nxt;
            r_busy       <= w_busy_nxt;
            if (w_last_upd) r_last_ms <= w_last_val;
        end
    end

`ifdef REACTION_BEST_EN
    logic [9:0] r_best_ms;
    // only stop-terminated runs compete; timeouts and early presses never reach here
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          r_best_ms <= 10'd1023;
        else if (w_best_upd && (w_last_val < r_best_ms))    r_best_ms <= w_last_val;
    end
    assign best_ms = r_best_ms;
`endif

    assign cnt_enable = r_cnt_enable;
    assign cnt_stop   = r_cnt_stop;
    assign cnt_clear  = r_cnt_clear;
    assign disp_sel   = r_disp_sel;
    assign busy       = r_busy;
    assign last_ms    = r_last_ms;
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl: stimulus queues expected strobes, a monitor checks them.
// A shortened minimum delay keeps every run within a few thousand ms ticks.
module tb_reaction_timer_ctrl;
    localparam int TF  = 9;
    localparam int TPM = TF + 1;
    localparam int MIN = 600;
    localparam int TO  = 1000;
    localparam logic [2:0] K_EN = 3'b100, K_STP = 3'b010, K_CLR = 3'b001;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic       cnt_enable, cnt_stop, cnt_clear, busy;
    logic [1:0] disp_sel;
    logic [9:0] last_ms;
`ifdef REACTION_BEST_EN
    logic [9:0] best_ms;
`endif

    reaction_timer_ctrl #(.TICK_FINAL(TF), .MIN_DELAY_MS(MIN), .DELAY_RAND_BITS(13),
                          .TIMEOUT_MS(TO), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .cnt_enable(cnt_enable), .cnt_stop(cnt_stop), .cnt_clear(cnt_clear),
        .disp_sel(disp_sel), .busy(busy),
`ifdef REACTION_BEST_EN
        .best_ms(best_ms),
`endif
        .last_ms(last_ms)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
        logic [1:0] disp;
        logic       busy;
        logic [9:0] last;
        logic [9:0] best;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic [2:0]  mk;
    int          checks = 0, errors = 0;
    int          cyc = 0;
    logic [15:0] lm;
    logic [9:0]  exp_last, exp_best;
    int          ws, d, t0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference LFSR: Fibonacci, taps 16,14,13,11
    always @(posedge clk or posedge reset)
        if (reset) lm <= 16'hACE1;
        else       lm <= {lm[14:0], lm[15] ^ lm[13] ^ lm[12] ^ lm[10]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                me = q.pop_front();
                checks++; errors++;
                $display("FAIL missed_strobe: got none expected kind %b at cycle %0d", me.kind, me.cyc);
            end
            mk = {cnt_enable, cnt_stop, cnt_clear};
            if (mk != 3'b000) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got %b at cycle %0d expected none", mk, cyc);
                end else begin
                    me = q.pop_front();
                    chk("strobe_kind", 32'(mk), 32'(me.kind));
                    chk("strobe_cycle", cyc, me.cyc);
                    chk("ev_disp_sel", 32'(disp_sel), 32'(me.disp));
                    chk("ev_busy", 32'(busy), 32'(me.busy));
                    chk("ev_last_ms", 32'(last_ms), 32'(me.last));
`ifdef REACTION_BEST_EN
                    chk("ev_best_ms", 32'(best_ms), 32'(me.best));
`endif
                end
            end
        end
    end

    task automatic expect_ev(input logic [2:0] k, input int c, input logic [1:0] dsp, input logic b);
        exp_t e;
        e.kind = k; e.cyc = c; e.disp = dsp; e.busy = b; e.last = exp_last; e.best = exp_best;
        q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // drive a one-cycle pulse sampled on clock edge number 'at'
    task automatic press(input int which, input int at);
        wait_to(at - 1);
        case (which)
            0: start = 1'b1;
            1: stop  = 1'b1;
            default: clear = 1'b1;
        endcase
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    // start when the reference LFSR low bits are small, so the delay stays near MIN
    task automatic begin_run(output int w, output int dly);
        int n = 0;
        while (lm[12:0] >= 13'd16 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30000) begin
            $display("FAIL lfsr_wait: got no small LFSR value expected one within 30000 cycles");
            $fatal(1);
        end
        dly   = MIN + int'(lm[12:0]);
        start = 1'b1;
        w     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("wait_disp_sel", 32'(disp_sel), 1);
        chk("wait_busy", 32'(busy), 1);
    endtask

    initial begin
        exp_last = 10'd0;
        exp_best = 10'd1023;
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({cnt_enable, cnt_stop, cnt_clear}), 0);
        chk("rst_disp_sel", 32'(disp_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_last_ms", 32'(last_ms), 0);
`ifdef REACTION_BEST_EN
        chk("rst_best_ms", 32'(best_ms), 1023);
`endif
        reset = 1'b0;
        @(negedge clk);

        // stop and clear in IDLE do nothing
        press(1, cyc + 2);
        press(2, cyc + 2);
        chk("idle_disp_sel", 32'(disp_sel), 0);

        // early press at 500 ms; start in WAIT ignored
        begin_run(ws, d);
        press(0, ws + 100);
        expect_ev(K_STP, ws + 500 * TPM, 2'd3, 1'b0);
        press(1, ws + 500 * TPM);
        wait_to(ws + d * TPM + 50);
        chk("early_disp_sel", 32'(disp_sel), 3);
        expect_ev(K_CLR, cyc + 5, 2'd0, 1'b0);
        press(2, cyc + 5);
        chk("early_clr_disp", 32'(disp_sel), 0);

        // timeout; later stop and start in DONE ignored
        begin_run(ws, d);
        t0 = ws + d * TPM;
        expect_ev(K_EN, t0, 2'd2, 1'b1);
        exp_last = 10'd1000;
        expect_ev(K_STP, t0 + TO * TPM, 2'd2, 1'b0);
        wait_to(t0 + TO * TPM + 50);
        press(1, cyc + 3);
        press(0, cyc + 3);
        chk("to_last_ms", 32'(last_ms), 1000);
        chk("to_disp_sel", 32'(disp_sel), 2);
        chk("to_busy", 32'(busy), 0);
        expect_ev(K_CLR, cyc + 5, 2'd0, 1'b0);
        press(2, cyc + 5);

        // normal run, stop after 237 ticks; start in TIMING ignored
        begin_run(ws, d);
        t0 = ws + d * TPM;
        expect_ev(K_EN, t0, 2'd2, 1'b1);
        press(0, t0 + 500);
        chk("timing_disp_sel", 32'(disp_sel), 2);
        chk("timing_busy", 32'(busy), 1);
        exp_last = 10'd237;
        exp_best = 10'd237;
        expect_ev(K_STP, t0 + 237 * TPM + 5, 2'd2, 1'b0);
        press(1, t0 + 237 * TPM + 5);
        expect_ev(K_CLR, cyc + 5, 2'd0, 1'b0);
        press(2, cyc + 5);

        // stop on the very tick that would time out: stop wins with 999
        begin_run(ws, d);
        t0 = ws + d * TPM;
        expect_ev(K_EN, t0, 2'd2, 1'b1);
        exp_last = 10'd999;
        expect_ev(K_STP, t0 + TO * TPM, 2'd2, 1'b0);
        press(1, t0 + TO * TPM);
        wait_to(cyc + 20);
        chk("coinc_last_ms", 32'(last_ms), 999);
        expect_ev(K_CLR, cyc + 5, 2'd0, 1'b0);
        press(2, cyc + 5);

        // asynchronous reset 100 ms into TIMING
        begin_run(ws, d);
        t0 = ws + d * TPM;
        expect_ev(K_EN, t0, 2'd2, 1'b1);
        wait_to(t0 + 100 * TPM);
        #2 reset = 1'b1;
        #1;
        chk("arst_strobes", 32'({cnt_enable, cnt_stop, cnt_clear}), 0);
        chk("arst_disp_sel", 32'(disp_sel), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_last_ms", 32'(last_ms), 0);
`ifdef REACTION_BEST_EN
        chk("arst_best_ms", 32'(best_ms), 1023);
`endif
        exp_last = 10'd0;
        exp_best = 10'd1023;
        @(negedge clk);
        reset = 1'b0;

        // run after reset: delay must follow the reseeded LFSR
        begin_run(ws, d);
        t0 = ws + d * TPM;
        expect_ev(K_EN, t0, 2'd2, 1'b1);
        exp_last = 10'd50;
        exp_best = 10'd50;
        expect_ev(K_STP, t0 + 50 * TPM + 5, 2'd2, 1'b0);
        press(1, t0 + 50 * TPM + 5);
        expect_ev(K_CLR, cyc + 5, 2'd0, 1'b0);
        press(2, cyc + 5);
        wait_to(cyc + 10);
        chk("final_disp_sel", 32'(disp_sel), 0);
        chk("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
